alu_mul_sequencer: RTL and testbench
====================================

# alu_mul_sequencer

Multi-cycle sequencer that computes the low 32 bits of a 32×32 multiply by driving the shared EX-stage ALU through shift-and-add steps (ADD, SLL, SRL). It sits between the pipeline EX stage and the ALU and owns the ALU input mux. When idle, pipeline ALU requests pass straight through. While a multiply runs, the sequencer holds the ALU and asserts `busy`, and the pipeline must stall on it.

## Interface
- `MUL_BITS`, 32: number of multiplier bits iterated; legal range 1..32; operands and product are always 32 bits.

- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request a multiply; sampled only in IDLE or DONE.
- `op_a` in 32: multiplicand, sampled with `start`.
- `op_b` in 32: multiplier, sampled with `start`.
- `busy` out 1: high in ADD, SHL and SHR states; this is the pipeline stall.
- `done` out 1: one-cycle pulse in the DONE state.
- `product` out 32: registered result; held until the next DONE.
- `pipe_alu_op` in 4: pipeline ALU opcode.
- `pipe_alu_in_1` in 32: pipeline ALU operand 1.
- `pipe_alu_in_2` in 32: pipeline ALU operand 2.
- `alu_op` out 4: opcode to the ALU.
- `alu_in_1` out 32: operand 1 to the ALU.
- `alu_in_2` out 32: operand 2 to the ALU.
- `alu_result` in 32: ALU result, combinational, same cycle.

## Operation
- Internal registers: `acc` (32), `mcand` (32), `mplier` (32), `count` (6), `state`.
- ALU opcodes used: ADD `4'b0001`, SLL `4'b0011`, SRL `4'b0101`; shift amount is always 1.
- ALU mux:
  - IDLE or DONE: `alu_*` = `pipe_alu_*` combinationally.
  - Any other state: the sequencer drives `alu_*`, and `pipe_alu_*` is ignored.
- Start: `start` high in IDLE or DONE latches `acc`=0, `mcand`=`op_a`, `mplier`=`op_b`, `count`=0, then applies the decision rule to `op_b`.
- Decision rule, evaluated on start and at the end of each SHR:
  - if `count`==`MUL_BITS` (or early exit, see Configuration) → DONE;
  - else if `mplier[0]` → ADD;
  - else → SHL.
- ADD state: `alu_op`=ADD, `alu_in_1`=`acc`, `alu_in_2`=`mcand`; `acc`<=`alu_result`; next state SHL.
- SHL state: `alu_op`=SLL, `alu_in_1`=`mcand`, `alu_in_2`=1; `mcand`<=`alu_result`; next state SHR.
- SHR state: `alu_op`=SRL, `alu_in_1`=`mplier`, `alu_in_2`=1; `mplier`<=`alu_result`; `count`<=`count`+1; decision rule uses the new `mplier` and `count`.
- Entering DONE: `product`<=`acc`. In DONE: `done`=1. Next state is IDLE, or a new run if `start` is high.
- Arithmetic is modulo 2^32. `mcand` bits shifted past bit 31 are lost. The result is correct for both signed and unsigned low-word multiply.
- `start` in ADD, SHL or SHR is ignored; there is no queueing.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `product`=0, all internal registers 0. Reset is asynchronous and takes effect mid-operation: the run aborts, no `done` is produced, and `product` is cleared.
- Cycle numbering: `start` is sampled at edge 0. Cycle 1 is the first sequencer state.
- Without early exit: each bit costs SHL+SHR (2 cycles) plus ADD (1 cycle) if the bit is set. DONE is in cycle 2·`MUL_BITS`+p+1, where p is the popcount of `op_b[MUL_BITS-1:0]`.
- `busy` is low in the `start` cycle and in DONE, so the pipeline sees the stall only in cycles 1..DONE-1.
- The pass-through path is purely combinational, with zero-cycle latency.

## Configuration
- `ALU_MUL_EARLY_EXIT_EN` defined:
  - the decision rule also exits to DONE when `mplier`==0;
  - `op_b`=0 gives DONE in cycle 1.
- Not defined:
  - always exactly `MUL_BITS` iterations;
  - latency depends only on popcount.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle → `busy`=0, `done`=0, `product`=0 immediately; `alu_*` mirror `pipe_alu_*`.
- Pass-through: idle, `pipe_alu_op`=`4'b0001`, operands 5/3 → `alu_op`=1, `alu_in_1`=5, `alu_in_2`=3 in the same cycle.
- 7×6:
  - → `product`=42;
  - DONE in cycle 67 without early exit;
  - with `ALU_MUL_EARLY_EXIT_EN`, DONE in cycle 9;
  - `busy` high in cycles 1..DONE-1, with the ALU ignoring `pipe_alu_*` during that window.
- `0xFFFFFFFF`×`0xFFFFFFFF` → `product`=`0x00000001`, DONE in cycle 97 under either config.
- Abort and ignore:
  - `start` pulsed in cycle 5 of a run → ignored; the result is still the first operands' product;
  - `reset` in cycle 10 of a run → no `done`; `product`=0.
- Back-to-back: `start` high in the DONE cycle with 3×4 → `done` pulses for the first product, then `product`=12 at the second DONE with no IDLE cycle between runs.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier that borrows the shared EX-stage ALU; passes pipeline ALU traffic through when idle.
// Optional feature: define ALU_MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module alu_mul_sequencer #(
    parameter int MUL_BITS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    input  logic [3:0]  pipe_alu_op,
    input  logic [31:0] pipe_alu_in_1,
    input  logic [31:0] pipe_alu_in_2,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_in_1,
    output logic [31:0] alu_in_2,
    input  logic [31:0] alu_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHL,
        S_SHR,
        S_DONE
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [5:0] COUNT_LAST = 6'(MUL_BITS);

    state_t      state;
    state_t      next_state;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [5:0]  count;
    logic [5:0]  count_inc;
    logic        accept;

    assign accept    = start && (state == S_IDLE || state == S_DONE);
    assign count_inc = count + 6'd1;

    // Shared decision rule: applied to op_b at start and to the freshly shifted multiplier after SHR.
    function automatic state_t decide(input logic [31:0] mp, input logic [5:0] cnt);
        state_t nxt;
        if (cnt == COUNT_LAST)
            nxt = S_DONE;
`ifdef ALU_MUL_EARLY_EXIT_EN
        else if (mp == '0)
            nxt = S_DONE;
`endif
        else if (mp[0])
            nxt = S_ADD;
        else
            nxt = S_SHL;
        return nxt;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves next_state unassigned (no latch).
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = decide(op_b, 6'd0);
            S_ADD:   next_state = S_SHL;
            S_SHL:   next_state = S_SHR;
            S_SHR:   next_state = decide(alu_result, count_inc);
            S_DONE:  next_state = start ? decide(op_b, 6'd0) : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == S_ADD) || (state == S_SHL) || (state == S_SHR);
        done     = (state == S_DONE);
        alu_op   = pipe_alu_op;
        alu_in_1 = pipe_alu_in_1;
        alu_in_2 = pipe_alu_in_2;
        case (state)
            S_ADD: begin
                alu_op   = OP_ADD;
                alu_in_1 = acc;
                alu_in_2 = mcand;
            end
            S_SHL: begin
                alu_op   = OP_SLL;
                alu_in_1 = mcand;
                alu_in_2 = 32'd1;
            end
            S_SHR: begin
                alu_op   = OP_SRL;
                alu_in_1 = mplier;
                alu_in_2 = 32'd1;
            end
            default: ;
        endcase
    end

    // Datapath: each state writes back exactly one register from the ALU result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            product <= '0;
        end else if (accept) begin
            acc    <= '0;
            mcand  <= op_a;
            mplier <= op_b;
            count  <= '0;
            if (next_state == S_DONE)
                product <= '0;
        end else begin
            case (state)
                S_ADD: acc <= alu_result;
                S_SHL: mcand <= alu_result;
                S_SHR: begin
                    mplier <= alu_result;
                    count  <= count_inc;
                    if (next_state == S_DONE)
                        product <= acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: behavioural ALU, product scoreboard, and latency model from op_b.
module tb_alu_mul_sequencer;

    localparam int MUL_BITS = 32;
    localparam int LIMIT    = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] product;
    logic [3:0]  pipe_alu_op;
    logic [31:0] pipe_alu_in_1, pipe_alu_in_2;
    logic [3:0]  alu_op;
    logic [31:0] alu_in_1, alu_in_2;
    logic [31:0] alu_result;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] exp_q[$];

    alu_mul_sequencer #(.MUL_BITS(MUL_BITS)) dut (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .product(product),
        .pipe_alu_op(pipe_alu_op), .pipe_alu_in_1(pipe_alu_in_1), .pipe_alu_in_2(pipe_alu_in_2),
        .alu_op(alu_op), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    // Shared EX-stage ALU, combinational.
    always_comb begin
        case (alu_op)
            4'b0001: alu_result = alu_in_1 + alu_in_2;
            4'b0011: alu_result = alu_in_1 << alu_in_2[4:0];
            4'b0101: alu_result = alu_in_1 >> alu_in_2[4:0];
            default: alu_result = alu_in_1 ^ alu_in_2;
        endcase
    end

    // Cycle number of DONE, counting the first sequencer state as cycle 1.
    function automatic int model_cycles(input logic [31:0] b);
        int          c;
        logic [31:0] mp;
        c  = 0;
        mp = b;
        for (int i = 0; i < MUL_BITS; i++) begin
`ifdef ALU_MUL_EARLY_EXIT_EN
            if (mp == '0) break;
`endif
            if (mp[0]) c += 1;
            c += 2;
            mp = mp >> 1;
        end
        return c + 1;
    endfunction

    task automatic set_pipe_junk();
        pipe_alu_op   = 4'hF;
        pipe_alu_in_1 = 32'hDEAD_BEEF;
        pipe_alu_in_2 = 32'hCAFE_F00D;
    endtask

    task automatic do_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        exp_q.push_back(a * b);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Runs from cycle 1 until done or LIMIT; cyc is -1 on timeout. Optionally pulses a stray start.
    task automatic run_to_done(input int stray_cyc, output int cyc, output int busy_cnt,
                               output int leak_cnt, output logic [31:0] prod);
        cyc = -1; busy_cnt = 0; leak_cnt = 0; prod = '0;
        for (int c = 1; c <= LIMIT; c++) begin
            if (busy) busy_cnt++;
            if (done) begin
                cyc  = c;
                prod = product;
                return;
            end
            if (busy && (alu_op === pipe_alu_op || alu_in_2 === pipe_alu_in_2)) leak_cnt++;
            if (c == stray_cyc) begin
                start = 1'b1;
                op_a  = 32'd9;
                op_b  = 32'd9;
            end
            @(posedge clk);
            #1 start = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        pipe_alu_op   = 4'h2;
        pipe_alu_in_1 = 32'h11;
        pipe_alu_in_2 = 32'h22;
        #12;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0) begin
            n_fails++;
            $display("FAIL reset_state: busy=%b done=%b product=%h, want 0 0 0", busy, done, product);
        end
        n_checks++;
        if (alu_op !== 4'h2 || alu_in_1 !== 32'h11 || alu_in_2 !== 32'h22) begin
            n_fails++;
            $display("FAIL reset_mirror: alu=%h/%h/%h, want 2/11/22", alu_op, alu_in_1, alu_in_2);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        pipe_alu_op   = 4'b0001;
        pipe_alu_in_1 = 32'd5;
        pipe_alu_in_2 = 32'd3;
        #1;
        n_checks++;
        if (alu_op !== 4'd1 || alu_in_1 !== 32'd5 || alu_in_2 !== 32'd3) begin
            n_fails++;
            $display("FAIL passthrough: alu=%h/%0d/%0d, want 1/5/3", alu_op, alu_in_1, alu_in_2);
        end
    endtask

    task automatic test_mul_7x6();
        int cyc, bc, lc;
        logic [31:0] prod, exp;
        set_pipe_junk();
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fails++;
            $display("FAIL busy_idle: busy=%b, want 0", busy);
        end
        do_start(32'd7, 32'd6);
        run_to_done(0, cyc, bc, lc, prod);
        exp = exp_q.pop_front();
        n_checks++;
        if (prod !== exp) begin
            n_fails++;
            $display("FAIL mul_7x6_product: got %0d, want %0d", prod, exp);
        end
        n_checks++;
`ifdef ALU_MUL_EARLY_EXIT_EN
        if (cyc !== 9) begin
            n_fails++;
            $display("FAIL mul_7x6_done_cycle: got %0d, want 9", cyc);
        end
`else
        if (cyc !== 67) begin
            n_fails++;
            $display("FAIL mul_7x6_done_cycle: got %0d, want 67", cyc);
        end
`endif
        n_checks++;
        if (bc !== cyc - 1 || lc !== 0) begin
            n_fails++;
            $display("FAIL mul_7x6_busy: busy cycles %0d leaks %0d, want %0d and 0", bc, lc, cyc - 1);
        end
    endtask

    task automatic test_all_ones();
        int cyc, bc, lc;
        logic [31:0] prod, exp;
        do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_to_done(0, cyc, bc, lc, prod);
        exp = exp_q.pop_front();
        n_checks++;
        if (prod !== exp || prod !== 32'h1) begin
            n_fails++;
            $display("FAIL all_ones_product: got %h, want 00000001", prod);
        end
        n_checks++;
        if (cyc !== 97) begin
            n_fails++;
            $display("FAIL all_ones_done_cycle: got %0d, want 97", cyc);
        end
    endtask

    task automatic test_start_ignored();
        int cyc, bc, lc;
        logic [31:0] prod, exp;
        do_start(32'd1234, 32'd5678);
        run_to_done(5, cyc, bc, lc, prod);
        exp = exp_q.pop_front();
        n_checks++;
        if (prod !== exp) begin
            n_fails++;
            $display("FAIL start_ignored_product: got %0d, want %0d", prod, exp);
        end
        n_checks++;
        if (cyc !== model_cycles(32'd5678)) begin
            n_fails++;
            $display("FAIL start_ignored_cycle: got %0d, want %0d", cyc, model_cycles(32'd5678));
        end
    endtask

    task automatic test_reset_abort();
        int n_done;
        do_start(32'h0001_2345, 32'h0000_0777);
        repeat (9) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        exp_q.delete();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0) begin
            n_fails++;
            $display("FAIL reset_abort: busy=%b done=%b product=%h, want 0 0 0", busy, done, product);
        end
        @(negedge clk);
        reset  = 1'b0;
        n_done = 0;
        repeat (100) begin
            @(posedge clk);
            #1 if (done) n_done++;
        end
        n_checks++;
        if (n_done !== 0 || product !== 32'd0) begin
            n_fails++;
            $display("FAIL reset_abort_no_done: done pulses %0d product %h, want 0 and 0", n_done, product);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bc, lc;
        logic [31:0] prod, exp;
        do_start(32'd5, 32'd9);
        run_to_done(0, cyc, bc, lc, prod);
        exp = exp_q.pop_front();
        n_checks++;
        if (cyc < 0 || prod !== exp) begin
            n_fails++;
            $display("FAIL b2b_first: cycle %0d product %0d, want done with %0d", cyc, prod, exp);
        end
        do_start(32'd3, 32'd4);
        run_to_done(0, cyc, bc, lc, prod);
        exp = exp_q.pop_front();
        n_checks++;
        if (prod !== exp || prod !== 32'd12) begin
            n_fails++;
            $display("FAIL b2b_second_product: got %0d, want 12", prod);
        end
        n_checks++;
        if (cyc !== model_cycles(32'd4) || bc !== cyc - 1) begin
            n_fails++;
            $display("FAIL b2b_second_timing: cycle %0d busy %0d, want %0d and %0d",
                     cyc, bc, model_cycles(32'd4), model_cycles(32'd4) - 1);
        end
    endtask

    task automatic test_operands();
        logic [31:0] a_tab[6] = '{32'd0, 32'h1234_5678, 32'hFFFF_FFFE, 32'd3, 32'h8000_0001, 32'd0};
        logic [31:0] b_tab[6] = '{32'd0, 32'd0, 32'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        int cyc, bc, lc;
        logic [31:0] prod, exp;
        a_tab[5] = $urandom;
        b_tab[5] = $urandom;
        for (int i = 0; i < 6; i++) begin
            do_start(a_tab[i], b_tab[i]);
            run_to_done(0, cyc, bc, lc, prod);
            exp = exp_q.pop_front();
            n_checks++;
            if (prod !== exp || cyc !== model_cycles(b_tab[i])) begin
                n_fails++;
                $display("FAIL operands_%0d: product %h cycle %0d, want %h cycle %0d",
                         i, prod, cyc, exp, model_cycles(b_tab[i]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_mul_7x6();
        test_all_ones();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_operands();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
